hv_assoc_search: RTL and testbench
==================================

// Module: hv_assoc_search
// PURPOSE
// Decoder-side counterpart of the HV encoder ALU: an associative-memory search engine.
// It accepts a query hypervector and optionally undoes the encoder's circular right shift
// by rotating left. It then streams stored class HVs from an item memory, one outstanding
// read at a time, and computes the Hamming distance popcount(query ^ class) for each.
// It returns the index and distance of the nearest class.
// It sits between the encoder output and the class/item memory.
// PARAMETERS
// HVDimension    512                       hypervector width in bits
// NumClasses     32                        max stored classes
// ClassAddrWidth $clog2(NumClasses)        class index/address width
// MaxShiftAmt    4                         number of un-shift modes
// ShiftWidth     $clog2(MaxShiftAmt)       width of shift_amt_i
// DistWidth      $clog2(HVDimension+1)     Hamming distance width
// PORTS
// clk_i            in  1                 clock, rising edge
// rst_ni           in  1                 async active-low reset
// query_i          in  HVDimension       query HV, sampled on query handshake
// query_valid_i    in  1                 query valid
// query_ready_o    out 1                 high only in IDLE
// num_classes_i    in  ClassAddrWidth+1  classes to search, sampled on query handshake
// unshift_en_i     in  1                 1: rotate query left before search, sampled on handshake
// shift_amt_i      in  ShiftWidth        0:1, 1:4, 2:8, 3:16 bit left rotation
// mem_addr_o       out ClassAddrWidth    class index being read
// mem_req_valid_o  out 1                 read request valid
// mem_req_ready_i  in  1                 memory accepts request
// mem_rsp_data_i   in  HVDimension       class HV returned
// mem_rsp_valid_i  in  1                 response valid, always accepted in WAIT
// pred_o           out ClassAddrWidth    nearest class index
// dist_o           out DistWidth         Hamming distance of pred_o
// result_valid_o   out 1                 result valid
// result_ready_i   in  1                 result consumed
// busy_o           out 1                 state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; query/pred/dist/min/index registers=0; mem_req_valid_o=0.
//   Also result_valid_o=0, busy_o=0, query_ready_o=1.
// - Query capture: on query_valid_i&&query_ready_o, register the query, rotated if unshift_en_i.
//   Left rotation by k is {A[HVDimension-1-k:0], A[HVDimension-1:HVDimension-k]}.
// - num_classes_i: values >NumClasses are clamped to NumClasses.
//   0 goes IDLE->DONE with pred_o=0, dist_o='1.
// - FSM IDLE->REQ on query handshake. In REQ, mem_req_valid_o=1 and mem_addr_o=idx, held stable.
//   REQ->WAIT on mem_req_ready_i.
// - WAIT: mem_rsp_valid_i computes d=popcount(q^rsp) that cycle.
//   If d<min (strict, so a tie keeps the lower index), then min<=d and best<=idx.
//   Then idx==N-1 goes to DONE, else idx++ and back to REQ.
// - mem_rsp_valid_i outside WAIT is ignored. A response is never expected in the cycle
//   of the request handshake.
// - min initialises to all-ones at capture, so class 0 always wins the first compare.
//   The idx counter restarts at 0.
// - DONE: result_valid_o=1 with pred_o/dist_o stable. DONE->IDLE on result_ready_i.
//   pred_o/dist_o then hold until the next capture.
// - Latency: with mem_req_ready_i=1 and 1-cycle response, result_valid_o rises
//   2*N+1 cycles after the query handshake.
// - Async reset mid-search aborts immediately. Any in-flight response is dropped.
// - Distance arithmetic: popcount of HVDimension bits into DistWidth, no overflow.
// TESTING
// 1. N=8, class5==query, others random, ready=1, 1-cycle rsp -> pred_o=5, dist_o=0,
//    result_valid_o 17 cycles after query handshake.
// 2. N=8, classes 2 and 6 both distance 3 from query, rest >=10 -> pred_o=2, dist_o=3.
// 3. query = class3 right-rotated by 4, unshift_en_i=1, shift_amt_i=1 -> pred_o=3, dist_o=0.
//    Repeat for shift codes 0, 2 and 3.
// 4. Random mem_req_ready_i stalls, rsp latency 1-5 cycles, result_ready_i low for 10 cycles
//    -> mem_addr_o stable while stalled, result stable, query_ready_o=0, matches golden model.
// 5. Assert rst_ni mid-search at idx=4, then send a stale mem_rsp_valid_i
//    -> all outputs at reset values, stale rsp ignored, next query correct.
// 6. num_classes_i=0 -> pred_o=0, dist_o='1. num_classes_i=NumClasses+1 -> only
//    NumClasses reads issued (max addr NumClasses-1).

Source files
------------

// File: rtl/hv_assoc_search.sv
// hv_assoc_search: associative-memory search over stored class hypervectors.
// It captures a query and can un-rotate it to undo the encoder's right shift.
// It then reads the class HVs one at a time, one outstanding read, and keeps the
// nearest class by Hamming distance. Ties keep the lower index.

// Per-lane popcount of one VEC_W-bit slice of the query/class difference.
module hv_assoc_popcnt_lane #(
    parameter int VEC_W = 64,
    parameter int CNT_W = $clog2(VEC_W + 1)
) (
    input  logic [VEC_W-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count set bits of the lane slice.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

module hv_assoc_search #(
    parameter int HVDimension    = 512,
    parameter int NumClasses     = 32,
    parameter int ClassAddrWidth = $clog2(NumClasses),
    parameter int MaxShiftAmt    = 4,
    parameter int ShiftWidth     = $clog2(MaxShiftAmt),
    parameter int DistWidth      = $clog2(HVDimension + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [HVDimension-1:0]    query_i,
    input  logic                      query_valid_i,
    output logic                      query_ready_o,
    input  logic [ClassAddrWidth:0]   num_classes_i,
    input  logic                      unshift_en_i,
    input  logic [ShiftWidth-1:0]     shift_amt_i,
    output logic [ClassAddrWidth-1:0] mem_addr_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    input  logic [HVDimension-1:0]    mem_rsp_data_i,
    input  logic                      mem_rsp_valid_i,
    output logic [ClassAddrWidth-1:0] pred_o,
    output logic [DistWidth-1:0]      dist_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      busy_o
);

    // The distance adder tree is split into equal lanes; HVDimension must divide evenly.
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = HVDimension / NUM_LANES;
    localparam int LANE_CW   = $clog2(VEC_W + 1);

    localparam logic [ClassAddrWidth:0] N_MAX = (ClassAddrWidth + 1)'(NumClasses);
    localparam logic [ClassAddrWidth:0] N_ONE = (ClassAddrWidth + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic [HVDimension-1:0]          query_q;
    logic [HVDimension-1:0]          query_rot;
    logic [ClassAddrWidth:0]         n_q, n_clamped;
    logic [ClassAddrWidth-1:0]       idx_q, best_q;
    logic [DistWidth-1:0]            min_q, dist_cur;
    logic                            last_idx;
    logic                            capture;
    logic                            rsp_take;

    logic [NUM_LANES-1:0][VEC_W-1:0]   diff_lanes;
    logic [NUM_LANES-1:0][LANE_CW-1:0] lane_cnt;

    assign capture   = (state_q == S_IDLE) && query_valid_i;
    assign rsp_take  = (state_q == S_WAIT) && mem_rsp_valid_i;
    assign n_clamped = (num_classes_i > N_MAX) ? N_MAX : num_classes_i;
    assign last_idx  = ({1'b0, idx_q} == (n_q - N_ONE));

    // Left rotation undoing the encoder's right shift: codes 0..3 map to 1/4/8/16 bits.
    always_comb begin
        case (shift_amt_i)
            2'd1:    query_rot = {query_i[HVDimension-5:0],  query_i[HVDimension-1:HVDimension-4]};
            2'd2:    query_rot = {query_i[HVDimension-9:0],  query_i[HVDimension-1:HVDimension-8]};
            2'd3:    query_rot = {query_i[HVDimension-17:0], query_i[HVDimension-1:HVDimension-16]};
            default: query_rot = {query_i[HVDimension-2:0],  query_i[HVDimension-1]};
        endcase
    end

    assign diff_lanes = query_q ^ mem_rsp_data_i;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        hv_assoc_popcnt_lane #(
            .VEC_W (VEC_W),
            .CNT_W (LANE_CW)
        ) u_lane (
            .vec_i (diff_lanes[g]),
            .cnt_o (lane_cnt[g])
        );
    end

    // Sum the lane counts into the full Hamming distance.
    always_comb begin
        dist_cur = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            dist_cur = dist_cur + DistWidth'(lane_cnt[l]);
        end
    end

    // State register; reset aborts any search and drops in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: one outstanding read, REQ/WAIT per class.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (query_valid_i)   state_d = (n_clamped == '0) ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready_i) state_d = S_WAIT;
            S_WAIT: if (mem_rsp_valid_i) state_d = last_idx ? S_DONE : S_REQ;
            S_DONE: if (result_ready_i)  state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Query capture and running nearest-class tracking; min starts all-ones so class 0 wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            query_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            best_q  <= '0;
            min_q   <= '0;
        end else if (capture) begin
            query_q <= unshift_en_i ? query_rot : query_i;
            n_q     <= n_clamped;
            idx_q   <= '0;
            best_q  <= '0;
            min_q   <= '1;
        end else if (rsp_take) begin
            if (dist_cur < min_q) begin
                min_q  <= dist_cur;
                best_q <= idx_q;
            end
            if (!last_idx) idx_q <= idx_q + ClassAddrWidth'(1);
        end
    end

    assign query_ready_o   = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_addr_o      = idx_q;
    assign result_valid_o  = (state_q == S_DONE);
    assign pred_o          = best_q;
    assign dist_o          = min_q;

endmodule

// File: tb/tb_hv_assoc_search.sv
// Directed bench for hv_assoc_search with a behavioural class memory.
module tb_hv_assoc_search;

    localparam int D  = 512;
    localparam int NC = 32;
    localparam int AW = 5;
    localparam int DW = 10;

    logic          clk_i = 0;
    logic          rst_ni = 0;
    logic [D-1:0]  query_i = '0;
    logic          query_valid_i = 0;
    logic          query_ready_o;
    logic [AW:0]   num_classes_i = '0;
    logic          unshift_en_i = 0;
    logic [1:0]    shift_amt_i = '0;
    logic [AW-1:0] mem_addr_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1;
    logic [D-1:0]  mem_rsp_data_i;
    logic          mem_rsp_valid_i;
    logic [AW-1:0] pred_o;
    logic [DW-1:0] dist_o;
    logic          result_valid_o;
    logic          result_ready_i = 0;
    logic          busy_o;

    hv_assoc_search dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .query_i         (query_i),
        .query_valid_i   (query_valid_i),
        .query_ready_o   (query_ready_o),
        .num_classes_i   (num_classes_i),
        .unshift_en_i    (unshift_en_i),
        .shift_amt_i     (shift_amt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .pred_o          (pred_o),
        .dist_o          (dist_o),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [D-1:0] cls [NC];
    int n_checks = 0;
    int n_fail   = 0;
    int stall_err = 0;
    int qr_err    = 0;

    // memory-model controls (main writes rsp_rand/stale_*; memory writes the rest)
    bit           rsp_rand = 0;
    int           stale_req = 0;
    int           stale_ack = 0;
    logic [D-1:0] stale_data = '0;
    int           n_reads = 0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] m_addr;
    int           m_lat;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [D-1:0] rand_hv();
        logic [D-1:0] r;
        for (int i = 0; i < D / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [D-1:0] rotl(input logic [D-1:0] a, input int k);
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[(i + k) % D] = a[i];
        return r;
    endfunction

    function automatic logic [D-1:0] rotr(input logic [D-1:0] a, input int k);
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[i] = a[(i + k) % D];
        return r;
    endfunction

    // Golden nearest-class search: returns {pred, dist}.
    function automatic logic [AW+DW-1:0] model(input logic [D-1:0] q, input int n);
        int nn;
        int best;
        int mind;
        int d;
        nn = (n > NC) ? NC : n;
        best = 0;
        mind = 1023;
        for (int c = 0; c < nn; c++) begin
            d = $countones(q ^ cls[c]);
            if (d < mind) begin
                mind = d;
                best = c;
            end
        end
        return {AW'(best), DW'(mind)};
    endfunction

    // Class memory: one request at a time, response 1 cycle (or 1-5 random) after handshake.
    initial begin
        mem_rsp_valid_i = 0;
        mem_rsp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            if (stale_req != stale_ack) begin
                stale_ack = stale_req;
                mem_rsp_data_i  = stale_data;
                mem_rsp_valid_i = 1;
                @(posedge clk_i);
                #1 mem_rsp_valid_i = 0;
            end else if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
                m_addr = mem_addr_o;
                n_reads++;
                last_addr = m_addr;
                m_lat = rsp_rand ? int'($urandom_range(1, 5)) : 1;
                repeat (m_lat) @(posedge clk_i);
                #1;
                mem_rsp_data_i  = cls[m_addr];
                mem_rsp_valid_i = 1;
                @(posedge clk_i);
                #1 mem_rsp_valid_i = 0;
            end
        end
    end

    task automatic run_query(input logic [D-1:0] q, input logic [AW:0] n, input logic en,
                             input logic [1:0] sa, input bit rnd, input string tag,
                             output logic [AW-1:0] p, output logic [DW-1:0] d, output int lat);
        bit prev_stall;
        logic [AW-1:0] prev_addr;
        @(negedge clk_i);
        query_i = q;
        num_classes_i = n;
        unshift_en_i = en;
        shift_amt_i = sa;
        rsp_rand = rnd;
        query_valid_i = 1;
        @(posedge clk_i);
        #1 query_valid_i = 0;
        lat = 0;
        prev_stall = 0;
        prev_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            lat++;
            if (prev_stall && (!mem_req_valid_o || mem_addr_o != prev_addr)) stall_err++;
            if (busy_o && query_ready_o) qr_err++;
            prev_stall = mem_req_valid_o && !mem_req_ready_i;
            prev_addr = mem_addr_o;
            if (result_valid_o) break;
            @(posedge clk_i);
            #1;
            if (rnd) mem_req_ready_i = 1'($urandom_range(0, 1));
        end
        mem_req_ready_i = 1;
        check({tag, "_done"}, 64'(result_valid_o), 64'd1);
        p = pred_o;
        d = dist_o;
    endtask

    // Hold result_ready low for a while, then consume; returns stability violations.
    task automatic consume(input int hold, input logic [AW-1:0] p, input logic [DW-1:0] d,
                           output int herr);
        herr = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (pred_o != p || dist_o != d || !result_valid_o || query_ready_o) herr++;
        end
        @(negedge clk_i);
        result_ready_i = 1;
        @(posedge clk_i);
        #1 result_ready_i = 0;
    endtask

    logic [AW-1:0] p;
    logic [DW-1:0] d;
    int lat;
    int herr;
    int reads0;
    logic [D-1:0] q;
    logic [AW+DW-1:0] exp_pd;
    int amt_tab [4] = '{1, 4, 8, 16};

    initial begin
        for (int c = 0; c < NC; c++) cls[c] = rand_hv();

        // reset state
        #12;
        check("rst_qready", 64'(query_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_rvalid", 64'(result_valid_o), 64'd0);
        check("rst_memreq", 64'(mem_req_valid_o), 64'd0);
        check("rst_pred", 64'(pred_o), 64'd0);
        check("rst_dist", 64'(dist_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1;

        // 1: exact match at class 5, latency 2N+1
        q = rand_hv();
        cls[5] = q;
        run_query(q, 6'd8, 1'b0, 2'd0, 0, "t1", p, d, lat);
        check("t1_pred", 64'(p), 64'd5);
        check("t1_dist", 64'(d), 64'd0);
        check("t1_lat", 64'(lat), 64'd17);
        consume(0, p, d, herr);

        // 2: tie between classes 2 and 6 at distance 3 keeps the lower index
        q = rand_hv();
        cls[2] = q ^ ((D'(1) << 0) | (D'(1) << 1) | (D'(1) << 2));
        cls[6] = q ^ ((D'(1) << 100) | (D'(1) << 200) | (D'(1) << 300));
        run_query(q, 6'd8, 1'b0, 2'd0, 0, "t2", p, d, lat);
        check("t2_pred", 64'(p), 64'd2);
        check("t2_dist", 64'(d), 64'd3);
        consume(0, p, d, herr);

        // 3: un-shift undoes the encoder rotation for every shift code
        for (int k = 0; k < 4; k++) begin
            q = rotr(cls[3], amt_tab[k]);
            run_query(q, 6'd8, 1'b1, 2'(k), 0, $sformatf("t3_sh%0d", k), p, d, lat);
            check($sformatf("t3_sh%0d_pred", k), 64'(p), 64'd3);
            check($sformatf("t3_sh%0d_dist", k), 64'(d), 64'd0);
            consume(0, p, d, herr);
        end

        // 4: random request stalls and response latency, result held 10 cycles
        stall_err = 0;
        qr_err = 0;
        q = rand_hv();
        exp_pd = model(rotl(q, 8), 20);
        run_query(q, 6'd20, 1'b1, 2'd2, 1, "t4", p, d, lat);
        check("t4_pred", 64'(p), 64'(exp_pd[AW+DW-1:DW]));
        check("t4_dist", 64'(d), 64'(exp_pd[DW-1:0]));
        check("t4_addr_stable", 64'(stall_err), 64'd0);
        check("t4_qready_busy", 64'(qr_err), 64'd0);
        consume(10, p, d, herr);
        check("t4_result_hold", 64'(herr), 64'd0);
        check("t4_back_idle", 64'(query_ready_o), 64'd1);
        check("t4_pred_kept", 64'(pred_o), 64'(p));

        // 5: reset mid-search at idx 4, then a stale response
        q = rand_hv();
        @(negedge clk_i);
        query_i = q;
        num_classes_i = 6'd8;
        unshift_en_i = 0;
        rsp_rand = 0;
        query_valid_i = 1;
        @(posedge clk_i);
        #1 query_valid_i = 0;
        for (int c = 0; c < 200; c++) begin
            if (mem_req_valid_o && mem_addr_o == 5'd4) break;
            @(posedge clk_i);
            #1;
        end
        mem_req_ready_i = 0;
        check("t5_at_idx4", 64'(mem_addr_o), 64'd4);
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        check("t5_rst_qready", 64'(query_ready_o), 64'd1);
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_memreq", 64'(mem_req_valid_o), 64'd0);
        check("t5_rst_addr", 64'(mem_addr_o), 64'd0);
        check("t5_rst_pred", 64'(pred_o), 64'd0);
        check("t5_rst_dist", 64'(dist_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1;
        mem_req_ready_i = 1;
        @(posedge clk_i);
        #1;
        stale_data = q;
        stale_req++;
        repeat (3) @(negedge clk_i);
        check("t5_stale_busy", 64'(busy_o), 64'd0);
        check("t5_stale_rvalid", 64'(result_valid_o), 64'd0);
        check("t5_stale_pred", 64'(pred_o), 64'd0);
        check("t5_stale_dist", 64'(dist_o), 64'd0);
        run_query(cls[6], 6'd8, 1'b0, 2'd0, 0, "t5", p, d, lat);
        check("t5_next_pred", 64'(p), 64'd6);
        check("t5_next_dist", 64'(d), 64'd0);
        consume(0, p, d, herr);

        // 6: zero classes, then clamping of an oversized count
        run_query(rand_hv(), 6'd0, 1'b0, 2'd0, 0, "t6z", p, d, lat);
        check("t6z_pred", 64'(p), 64'd0);
        check("t6z_dist", 64'(d), 64'h3ff);
        check("t6z_lat", 64'(lat), 64'd1);
        consume(0, p, d, herr);

        q = rand_hv();
        cls[31] = q;
        reads0 = n_reads;
        run_query(q, 6'd33, 1'b0, 2'd0, 0, "t6c", p, d, lat);
        check("t6c_pred", 64'(p), 64'd31);
        check("t6c_dist", 64'(d), 64'd0);
        check("t6c_reads", 64'(n_reads - reads0), 64'd32);
        check("t6c_last_addr", 64'(last_addr), 64'd31);
        check("t6c_lat", 64'(lat), 64'd65);
        consume(0, p, d, herr);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
